// File: rtl/rf_ctrl_fsm_pkg.sv
// Shared types and encodings for the rf_ctrl_fsm sequencer.
// RF_CTRL_ILLEGAL_TRAP_EN adds the HALT state used to trap illegal instructions.
package rf_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WRITE_REG
`ifdef RF_CTRL_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

endpackage

// File: rtl/rf_ctrl_fsm_if.sv
// Instruction handshake and regfile/datapath control bundle for rf_ctrl_fsm.
// Handshake: w is the ready signal; instr_in is taken on the edge where w && s, s is ignored while w is low.
interface rf_ctrl_fsm_if;
  import rf_ctrl_pkg::*;

  logic              s;
  logic [DATA_W-1:0] instr_in;
  logic              w;
  logic              err;
  logic [REG_AW-1:0] readnum;
  logic [REG_AW-1:0] writenum;
  logic              write;
  logic              loada;
  logic              loadb;
  logic              loadc;
  logic              loads;
  logic              asel;
  logic              bsel;
  logic [1:0]        vsel;
  logic [DATA_W-1:0] sximm8;
  logic [1:0]        shift;
  logic [1:0]        aluop;
  state_t            state_dbg;

  modport master (
    output s, instr_in,
    input  w, err, readnum, writenum, write, loada, loadb, loadc, loads,
    input  asel, bsel, vsel, sximm8, shift, aluop, state_dbg
  );

  modport slave (
    input  s, instr_in,
    output w, err, readnum, writenum, write, loada, loadb, loadc, loads,
    output asel, bsel, vsel, sximm8, shift, aluop, state_dbg
  );

endinterface

// File: rtl/rf_ctrl_fsm_dec.sv
// Combinational instruction decoder: field split, imm8 sign extension and legality.
module rf_instr_dec
  import rf_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] ir,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [REG_AW-1:0] rn,
  output logic [REG_AW-1:0] rd,
  output logic [1:0]        sh,
  output logic [REG_AW-1:0] rm,
  output logic [DATA_W-1:0] sximm8,
  output logic              legal
);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

  // MOV only has the immediate and register forms; every ALU op is implemented.
  assign legal = (opcode == OPC_ALU) ||
                 ((opcode == OPC_MOV) && ((op == OP_MOV_IMM) || (op == OP_MOV_REG)));

endmodule

// File: rtl/rf_ctrl_fsm.sv
// Moore sequencer for the Simple RISC Machine regfile/ALU datapath.
// Build with RF_CTRL_ILLEGAL_TRAP_EN to trap illegal instructions in HALT with err=1.
module rf_ctrl_fsm
  import rf_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  rf_ctrl_fsm_if.slave  bus
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;

  logic [2:0]        opcode;
  logic [1:0]        op;
  logic [REG_AW-1:0] rn, rd, rm;
  logic [1:0]        sh;
  logic [DATA_W-1:0] sximm8;
  logic              legal;

  rf_instr_dec u_dec (
    .ir     (ir_q),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .sh     (sh),
    .rm     (rm),
    .sximm8 (sximm8),
    .legal  (legal)
  );

  logic is_mov, is_mov_imm, is_cmp;
  assign is_mov     = (opcode == OPC_MOV);
  assign is_mov_imm = is_mov && (op == OP_MOV_IMM);
  assign is_cmp     = (opcode == OPC_ALU) && (op == OP_CMP);

  always_comb begin
    ir_d = ir_q;
    if ((state_q == S_WAIT) && bus.s) ir_d = bus.instr_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:      if (bus.s) state_d = S_DECODE;
      S_DECODE: begin
        if (!legal) begin
`ifdef RF_CTRL_ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_WAIT;
`endif
        end else if (is_mov_imm) state_d = S_WRITE_IMM;
        else if (is_mov)         state_d = S_GET_B;
        else                     state_d = S_GET_A;
      end
      S_WRITE_IMM: state_d = S_WAIT;
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_ALU;
      S_ALU:       state_d = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
`ifdef RF_CTRL_ILLEGAL_TRAP_EN
      S_HALT:      state_d = S_HALT;
`endif
      default:     state_d = S_WAIT;
    endcase
  end

  logic              w_o, write_raw, loada_o, loadb_o, loadc_o, loads_o, asel_o;
  logic [REG_AW-1:0] readnum_o, writenum_o;
  logic [1:0]        vsel_o;

  always_comb begin
    w_o        = 1'b0;
    write_raw  = 1'b0;
    loada_o    = 1'b0;
    loadb_o    = 1'b0;
    loadc_o    = 1'b0;
    loads_o    = 1'b0;
    asel_o     = 1'b0;
    readnum_o  = '0;
    writenum_o = '0;
    vsel_o     = VSEL_C;
    case (state_q)
      S_WAIT:      w_o = 1'b1;
      S_WRITE_IMM: begin
        writenum_o = rn;
        vsel_o     = VSEL_IMM;
        write_raw  = 1'b1;
      end
      S_GET_A: begin
        readnum_o = rn;
        loada_o   = 1'b1;
      end
      S_GET_B: begin
        readnum_o = rm;
        loadb_o   = 1'b1;
      end
      S_ALU: begin
        // MOV reg runs as 0 + shifted Rm through the adder.
        asel_o  = is_mov;
        loads_o = is_cmp;
        loadc_o = !is_cmp;
      end
      S_WRITE_REG: begin
        writenum_o = rd;
        vsel_o     = VSEL_C;
        write_raw  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.w         = w_o;
  assign bus.write     = write_raw & ~reset;
  assign bus.loada     = loada_o;
  assign bus.loadb     = loadb_o;
  assign bus.loadc     = loadc_o;
  assign bus.loads     = loads_o;
  assign bus.asel      = asel_o;
  assign bus.bsel      = 1'b0;
  assign bus.readnum   = readnum_o;
  assign bus.writenum  = writenum_o;
  assign bus.vsel      = vsel_o;
  assign bus.sximm8    = sximm8;
  assign bus.shift     = is_mov_imm ? 2'b00 : sh;
  assign bus.aluop     = is_mov ? 2'b00 : op;
  assign bus.state_dbg = state_q;
`ifdef RF_CTRL_ILLEGAL_TRAP_EN
  assign bus.err       = (state_q == S_HALT);
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_rf_ctrl_fsm.sv
// Randomized bench for rf_ctrl_fsm: per-instruction expected output traces built from the ISA rules.
module tb_rf_ctrl_fsm;

  typedef struct packed {
    logic        w;
    logic        err;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] sximm8;
  } obs_t;

  localparam int OW = $bits(obs_t);

  logic clk = 1'b0;
  logic reset;

  rf_ctrl_fsm_if bus ();

  rf_ctrl_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] msk_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  logic [15:0]   last_sx  = '0;

  function automatic obs_t observe();
    obs_t o;
    o.w        = bus.w;
    o.err      = bus.err;
    o.readnum  = bus.readnum;
    o.writenum = bus.writenum;
    o.write    = bus.write;
    o.loada    = bus.loada;
    o.loadb    = bus.loadb;
    o.loadc    = bus.loadc;
    o.loads    = bus.loads;
    o.asel     = bus.asel;
    o.bsel     = bus.bsel;
    o.vsel     = bus.vsel;
    o.shift    = bus.shift;
    o.aluop    = bus.aluop;
    o.sximm8   = bus.sximm8;
    return o;
  endfunction

  task automatic check_eq(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t no_fields();
    obs_t m = '1;
    m.shift = 2'b00;
    m.aluop = 2'b00;
    return m;
  endfunction

  // Expected per-cycle outputs from the s-sample edge up to the return to idle.
  task automatic build_trace(input logic [15:0] ins);
    logic [2:0]  opc = ins[15:13];
    logic [1:0]  op  = ins[12:11];
    logic [15:0] sx  = {{8{ins[7]}}, ins[7:0]};
    bit movi = (opc == 3'b110) && (op == 2'b10);
    bit movr = (opc == 3'b110) && (op == 2'b00);
    bit alu  = (opc == 3'b101);
    bit cmp  = alu && (op == 2'b01);
    obs_t base = '0;
    obs_t e;
    obs_t m;
    base.sximm8 = sx;
    exp_q.push_back(base); msk_q.push_back(no_fields());
    if (movi) begin
      e = base; e.writenum = ins[10:8]; e.vsel = 2'b10; e.write = 1'b1; e.shift = 2'b00;
      m = no_fields(); m.shift = 2'b11;
      exp_q.push_back(e); msk_q.push_back(m);
    end else if (movr || alu) begin
      if (alu) begin
        e = base; e.readnum = ins[10:8]; e.loada = 1'b1;
        exp_q.push_back(e); msk_q.push_back(no_fields());
      end
      e = base; e.readnum = ins[2:0]; e.loadb = 1'b1;
      exp_q.push_back(e); msk_q.push_back(no_fields());
      e = base; e.asel = movr; e.aluop = movr ? 2'b00 : op; e.shift = ins[4:3];
      e.loads = cmp; e.loadc = !cmp;
      exp_q.push_back(e); msk_q.push_back('1);
      if (!cmp) begin
        e = base; e.writenum = ins[7:5]; e.vsel = 2'b00; e.write = 1'b1;
        exp_q.push_back(e); msk_q.push_back(no_fields());
      end
    end
  endtask

  task automatic check_idle(input string tag);
    obs_t e = '0;
    e.w = 1'b1;
    e.sximm8 = last_sx;
    check_eq(tag, observe() & no_fields(), e & no_fields());
  endtask

  task automatic check_reset_state(input string tag);
    obs_t e = '0;
    e.w = 1'b1;
    check_eq(tag, observe(), e);
  endtask

  // Called at a negedge while idle; returns at the negedge after the DUT is idle again.
  task automatic send(input logic [15:0] ins, input bit hold_s, input string tag);
    logic [OW-1:0] e, m;
    build_trace(ins);
    bus.s = 1'b1;
    bus.instr_in = ins;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      check_eq(tag, observe() & m, e & m);
      bus.s = hold_s;
      bus.instr_in = 16'($urandom);
    end
    last_sx = {{8{ins[7]}}, ins[7:0]};
    @(negedge clk);
    check_idle({tag, "_done"});
    bus.s = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      bus.s = 1'b0;
      bus.instr_in = 16'($urandom);
      @(negedge clk);
      check_idle("idle");
    end
  endtask

  function automatic logic [15:0] rand_instr(input bit allow_illegal);
    logic [15:0] r = 16'($urandom);
    logic [2:0]  opc;
    int kind = $urandom_range(0, allow_illegal ? 3 : 2);
    case (kind)
      0: return {3'b110, 2'b10, r[10:0]};
      1: return {3'b110, 2'b00, r[10:0]};
      2: return {3'b101, r[12:0]};
      default: begin
        opc = 3'($urandom_range(0, 7));
        if (opc == 3'b101) opc = 3'b111;
        if (opc == 3'b110) return {3'b110, ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11, r[10:0]};
        return {opc, r[12:0]};
      end
    endcase
  endfunction

  initial begin
    obs_t e;
    reset = 1'b1;
    bus.s = 1'b0;
    bus.instr_in = '0;
    repeat (2) @(negedge clk);
    check_reset_state("rst_hold");
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("rst_rel");

    send(16'hD007, 1'b0, "mov_r0_7");
    send(16'hD1FF, 1'b0, "mov_r1_m1");
    send(16'hA140, 1'b0, "add_r2");
    send(16'hA900, 1'b1, "cmp_r1");
    send(16'hC069, 1'b1, "mov_r3_lsl");
    send(16'hB8E5, 1'b0, "mvn");
    idle_cycles(2);

    // Reset while fetching B: back to an idle, cleared controller.
    bus.s = 1'b1; bus.instr_in = 16'hA140;
    @(negedge clk); bus.s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    e = '0; e.readnum = 3'd0; e.loadb = 1'b1; e.sximm8 = 16'h0040;
    check_eq("getb_pre_rst", observe() & no_fields(), e & no_fields());
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("rst_getb");
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("rst_getb_rel");
    last_sx = '0;

    // Reset arriving in WRITE_REG must suppress the write within the same cycle.
    bus.s = 1'b1; bus.instr_in = 16'hA140;
    @(negedge clk); bus.s = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("wr_pre_rst", OW'(bus.write), OW'(1'b1));
    reset = 1'b1;
    #1;
    check_eq("wr_gate", OW'(bus.write), OW'(1'b0));
    @(negedge clk);
    check_reset_state("rst_wr");
    reset = 1'b0;
    @(negedge clk);
    last_sx = '0;

`ifdef RF_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 60; i++) begin
      idle_cycles($urandom_range(0, 2));
      send(rand_instr(1'b0), 1'($urandom_range(0, 1)), "rand");
    end
    bus.s = 1'b1; bus.instr_in = 16'hE000;
    @(negedge clk);
    bus.s = 1'b0;
    check_eq("ill_dec", OW'({bus.w, bus.err, bus.write}), OW'(3'b000));
    repeat (3) begin
      @(negedge clk);
      bus.s = 1'b1;
      e = '0; e.err = 1'b1;
      check_eq("halt", observe() & no_fields(), e & no_fields());
    end
    bus.s = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("rst_halt");
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("rst_halt_rel");
`else
    send(16'hE000, 1'b0, "illegal");
    for (int i = 0; i < 60; i++) begin
      idle_cycles($urandom_range(0, 2));
      send(rand_instr(1'b1), 1'($urandom_range(0, 1)), "rand");
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
